// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT datapath types, Q15 constants and saturation helpers.
package fft_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} mult_state_t;
  localparam logic [15:0] Q15_ONE = 16'h7FFF;
  localparam logic [15:0] Q15_MIN = 16'h8000;
  localparam int MAX_W = 64;
  typedef logic signed [2*MAX_W:0] wide_t;
  function automatic wide_t sat_signed(input wide_t v, input int w);
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = ~hi;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  function automatic wide_t sat_unsigned(input wide_t v, input int w);
    wide_t hi;
    hi = (wide_t'(1) << w) - wide_t'(1);
    return v > hi ? hi : v < wide_t'(0) ? wide_t'(0) : v;
  endfunction
endpackage

// File: rtl/fx_round_sat.sv
// fx_round_sat: scales a 2*WIDTH product by FRAC bits with optional round-half-up, then saturates.
module fx_round_sat import fft_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int FRAC = 15,
  parameter int SIGNED = 1,
  parameter int ROUND = 1
) (
  input  logic [2*WIDTH-1:0] p_i,
  output logic [WIDTH-1:0]   res_o,
  output logic               ovf_o
);
  localparam int PW = 2*WIDTH + 1;
  localparam int RS = FRAC > 0 ? FRAC - 1 : 0;
  localparam logic signed [PW-1:0] RND = (ROUND != 0 && FRAC > 0) ? (PW'(1) << RS) : '0;
  logic signed [PW-1:0] pe, sum, r;
  wide_t re, sat;
  // guard bit keeps the rounding add from wrapping; it also carries the sign when SIGNED
  assign pe = {SIGNED != 0 && p_i[2*WIDTH-1], p_i};
  assign sum = pe + RND;
  assign r = sum >>> FRAC;
  assign re = wide_t'(r);
  assign sat = SIGNED != 0 ? sat_signed(re, WIDTH) : sat_unsigned(re, WIDTH);
  assign res_o = sat[WIDTH-1:0];
  assign ovf_o = sat != re;
endmodule

// File: rtl/seq_mult_fx.sv
// seq_mult_fx: sequential shift-add fixed-point multiplier with valid/ready handshake,
// one multiply in flight, Q-format rounding and saturation.
module seq_mult_fx import fft_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int FRAC = 15,
  parameter int SIGNED = 1,
  parameter int ROUND = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [2*WIDTH-1:0] product_full,
  output logic               overflow
);
  localparam int CW = $clog2(WIDTH);
  mult_state_t state_q, state_d;
  logic [WIDTH-1:0] mplier_q, mplier_d, a_mag, b_mag, res_fix, result_q, result_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, p_fix, prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, ovf_fix, ovf_q, ovf_d, sa, sb;
  // magnitudes are WIDTH-bit unsigned so the most negative operand stays exact
  assign sa = SIGNED != 0 && a_in[WIDTH-1];
  assign sb = SIGNED != 0 && b_in[WIDTH-1];
  assign a_mag = sa ? -a_in : a_in;
  assign b_mag = sb ? -b_in : b_in;
  assign p_fix = neg_q ? -acc_q : acc_q;
  fx_round_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .SIGNED(SIGNED), .ROUND(ROUND)) u_rs (
    .p_i(p_fix), .res_o(res_fix), .ovf_o(ovf_fix)
  );
  always_comb begin
    state_d = state_q;
    mplier_d = mplier_q;
    mcand_d = mcand_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    result_d = result_q;
    prod_d = prod_q;
    ovf_d = ovf_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        mplier_d = a_mag;
        mcand_d = {{WIDTH{1'b0}}, b_mag};
        neg_d = sa ^ sb;
        acc_d = '0;
        cnt_d = '0;
        state_d = BUSY;
      end
      BUSY: begin
        acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(WIDTH - 1) ? FIX : BUSY;
      end
      FIX: begin
        prod_d = p_fix;
        result_d = res_fix;
        ovf_d = ovf_fix;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mplier_q <= '0;
      mcand_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      result_q <= '0;
      prod_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mplier_q <= mplier_d;
      mcand_q <= mcand_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      result_q <= result_d;
      prod_q <= prod_d;
      ovf_q <= ovf_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result = result_q;
  assign product_full = prod_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_seq_mult_fx.sv
// tb_seq_mult_fx: random and directed checks of seq_mult_fx against an integer-arithmetic model.
module tb_seq_mult_fx;
  import fft_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic v16 = 1'b0, or16 = 1'b0, v8 = 1'b0, or8 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic rdy1, vld1, ovf1, rdy0, vld0, ovf0, rdy8, vld8, ovf8;
  logic [15:0] res1, res0, prod8;
  logic [31:0] prod1, prod0;
  logic [7:0] res8;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] lp;
  logic [15:0] lr1, lr0;
  logic lo1;

  always #5 clk = ~clk;

  seq_mult_fx u_r1 (.clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy1), .a_in(a16), .b_in(b16),
    .out_valid(vld1), .out_ready(or16), .result(res1), .product_full(prod1), .overflow(ovf1));
  seq_mult_fx #(.ROUND(0)) u_r0 (.clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy0), .a_in(a16), .b_in(b16),
    .out_valid(vld0), .out_ready(or16), .result(res0), .product_full(prod0), .overflow(ovf0));
  seq_mult_fx #(.WIDTH(8), .FRAC(0), .SIGNED(0)) u_u8 (.clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
    .a_in(a8), .b_in(b8), .out_valid(vld8), .out_ready(or8), .result(res8), .product_full(prod8), .overflow(ovf8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int w, input int f, input int s, input int rn, input longint a,
                                input longint b, output longint p, output longint r, output bit ov);
    longint t, hi, lo;
    p = a * b;
    t = (p + ((rn != 0 && f > 0) ? (longint'(1) << (f - 1)) : longint'(0))) >>> f;
    hi = s != 0 ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
    lo = s != 0 ? -(longint'(1) << (w - 1)) : longint'(0);
    r = t > hi ? hi : t < lo ? lo : t;
    ov = r != t;
  endfunction

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input int hold);
    longint p, r1m, r0m;
    bit o1m, o0m;
    int cyc;
    model(16, 15, 1, 1, longint'(signed'(a)), longint'(signed'(b)), p, r1m, o1m);
    model(16, 15, 1, 0, longint'(signed'(a)), longint'(signed'(b)), p, r0m, o0m);
    check("rdy16_pre", rdy1, 1);
    a16 = a; b16 = b; v16 = 1'b1; or16 = 1'b0;
    @(posedge clk); #1;
    v16 = 1'b0;
    cyc = 1;
    while (!vld1 && cyc < 40) begin
      a16 = 16'($urandom); b16 = 16'($urandom); v16 = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    v16 = 1'b0;
    check("lat16", cyc, 18);
    check("vld16_t", vld0, 1);
    check("prod16", prod1, p & 64'hFFFF_FFFF);
    check("prod16_t", prod0, p & 64'hFFFF_FFFF);
    check("res16_r", res1, r1m & 64'hFFFF);
    check("ovf16_r", ovf1, o1m);
    check("res16_t", res0, r0m & 64'hFFFF);
    check("ovf16_t", ovf0, o0m);
    for (int i = 0; i < hold; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); v16 = 1'($urandom);
      @(posedge clk); #1;
      check("hold_vld", vld1, 1);
      check("hold_rdy", rdy1, 0);
      check("hold_res", res1, r1m & 64'hFFFF);
      check("hold_prod", prod1, p & 64'hFFFF_FFFF);
      check("hold_ovf", ovf1, o1m);
    end
    v16 = 1'b0; or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    check("rel_rdy16", rdy1, 1);
    check("rel_vld16", vld1, 0);
    check("keep_res16", res1, r1m & 64'hFFFF);
    lp = prod1; lr1 = res1; lr0 = res0; lo1 = ovf1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    longint p, rm;
    bit om;
    int cyc;
    model(8, 0, 0, 1, longint'(a), longint'(b), p, rm, om);
    check("rdy8_pre", rdy8, 1);
    a8 = a; b8 = b; v8 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    cyc = 1;
    while (!vld8 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("lat8", cyc, 10);
    check("prod8", prod8, p & 64'hFFFF);
    check("res8", res8, rm & 64'hFF);
    check("ovf8", ovf8, om);
    @(posedge clk); #1;
    check("rel_rdy8", rdy8, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", rdy1, 1);
    check("rst_vld", vld1, 0);
    check("rst_res", res1, 0);
    check("rst_prod", prod1, 0);
    check("rst_ovf", ovf1, 0);
    check("rst_vld8", vld8, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run16(16'h4000, 16'h4000, 0);
    check("t1_prod", lp, 32'h1000_0000);
    check("t1_res", lr1, 16'h2000);
    check("t1_ovf", lo1, 0);
    run16(Q15_MIN, Q15_MIN, 10);
    check("t2_prod", lp, 32'h4000_0000);
    check("t2_res", lr1, Q15_ONE);
    check("t2_ovf", lo1, 1);
    run16(16'h7FFF, 16'h8001, 0);
    check("t3_prod", lp, 32'hC000_FFFF);
    check("t3_res_r", lr1, 16'h8002);
    check("t3_res_t", lr0, 16'h8001);
    run16(16'h0001, 16'h4000, 0);
    check("t4_prod", lp, 32'h0000_4000);
    check("t4_res_r", lr1, 16'h0001);
    check("t4_res_t", lr0, 16'h0000);
    run16(16'h0000, 16'h7FFF, 0);
    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 1) != 0 ? Q15_MIN : Q15_ONE;
      run16(ra, rb, int'($urandom_range(0, 2)));
    end
    a16 = 16'h1234; b16 = 16'h5678; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_vld", vld1, 0);
    check("mid_rdy", rdy1, 1);
    check("mid_res", res1, 0);
    check("mid_prod", prod1, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("mid_no_vld", vld1, 0);
    check("mid_rdy2", rdy1, 1);
    run8(8'd3, 8'd5);
    run8(8'd255, 8'd255);
    run8(8'd0, 8'd200);
    for (int i = 0; i < 20; i++) run8(8'($urandom), 8'($urandom_range(0, 3) == 0 ? 1 : $urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
